// File: rtl/key_repeat_pulse_pkg.sv
// Shared types and helpers for the key_repeat_pulse edge-to-pulse block.
package key_repeat_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // Bits needed to hold values 0..limit, never less than one.
  function automatic int unsigned cnt_w(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

  // A zero repeat interval falls back to the first-repeat delay.
  function automatic int unsigned repeat_interval(input int unsigned delay_cycles,
                                                  input int unsigned repeat_cycles);
    return (repeat_cycles != 0) ? repeat_cycles : delay_cycles;
  endfunction

endpackage

// File: rtl/key_repeat_channel.sv
// One key channel: level debouncer, press/auto-repeat FSM and its counters.
module key_repeat_channel
  import key_repeat_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DELAY_CYCLES    = 0,
  parameter int unsigned REPEAT_CYCLES   = 0,
  parameter int unsigned ON_FALL         = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic data,
  input  logic enable,
  output logic pulse,
  output logic held
);

  localparam int unsigned INTERVAL = repeat_interval(DELAY_CYCLES, REPEAT_CYCLES);
  localparam int unsigned HOLD_MAX = (DELAY_CYCLES > INTERVAL) ? DELAY_CYCLES : INTERVAL;
  localparam int unsigned DB_W     = cnt_w(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W   = cnt_w(HOLD_MAX);
  localparam int unsigned DLY_M1   = (DELAY_CYCLES > 0) ? DELAY_CYCLES - 1 : 0;
  localparam int unsigned INT_M1   = (INTERVAL > 0) ? INTERVAL - 1 : 0;

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DLY_LAST = HOLD_W'(DLY_M1);
  localparam logic [HOLD_W-1:0] INT_LAST = HOLD_W'(INT_M1);
  localparam logic              ACT_XOR  = (ON_FALL != 0);

  logic              level, level_next;
  logic [DB_W-1:0]   db_cnt, db_cnt_next;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
  state_t            state, state_next;
  logic              pulse_next;
  logic              active_now, active_next;

  always_comb begin
    level_next  = level;
    db_cnt_next = '0;
    if (data != level) begin
      if (db_cnt == DB_LAST) level_next = data;
      else                   db_cnt_next = db_cnt + 1'b1;
    end
  end

  assign active_now  = level ^ ACT_XOR;
  assign active_next = level_next ^ ACT_XOR;

  // The press pulse fires on the same edge the debounced level turns active.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    pulse_next    = 1'b0;
    if (!enable || !active_next) begin
      state_next    = ST_IDLE;
      hold_cnt_next = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!active_now) begin
            pulse_next    = 1'b1;
            hold_cnt_next = '0;
            state_next    = (DELAY_CYCLES != 0) ? ST_DELAY : ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (hold_cnt == DLY_LAST) begin
            pulse_next    = 1'b1;
            hold_cnt_next = '0;
            state_next    = ST_REPEAT;
          end else begin
            hold_cnt_next = hold_cnt + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (hold_cnt == INT_LAST) begin
            pulse_next    = 1'b1;
            hold_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt + 1'b1;
          end
        end
        default: begin
          state_next    = ST_IDLE;
          hold_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      level    <= data;
      db_cnt   <= '0;
      state    <= ST_IDLE;
      hold_cnt <= '0;
      pulse    <= 1'b0;
      held     <= data ^ ACT_XOR;
    end else begin
      level    <= level_next;
      db_cnt   <= db_cnt_next;
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
      pulse    <= pulse_next;
      held     <= active_next;
    end
  end

endmodule

// File: rtl/key_repeat_pulse.sv
// Multi-channel debounced key edge-to-pulse generator with optional auto-repeat.
module key_repeat_pulse
  import key_repeat_pulse_pkg::*;
#(
  parameter int unsigned CHANNELS        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DELAY_CYCLES    = 0,
  parameter int unsigned REPEAT_CYCLES   = 0,
  parameter int unsigned ON_FALL         = 0
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic [CHANNELS-1:0] i_Data,
  input  logic [CHANNELS-1:0] i_Enable,
  output logic [CHANNELS-1:0] o_Pulse,
  output logic [CHANNELS-1:0] o_Held,
  output logic                o_Any
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    key_repeat_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DELAY_CYCLES   (DELAY_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .ON_FALL        (ON_FALL)
    ) u_ch (
      .clk   (i_Clk),
      .rst   (i_Rst),
      .data  (i_Data[g]),
      .enable(i_Enable[g]),
      .pulse (o_Pulse[g]),
      .held  (o_Held[g])
    );
  end

  assign o_Any = |o_Pulse;

endmodule

// File: tb/tb_key_repeat_pulse.sv
// Randomized and directed bench for key_repeat_pulse against a timing-rule model.
module tb_key_repeat_pulse;

  localparam int CH = 4;
  localparam int M_DEB  [2] = '{3, 3};
  localparam int M_DLY  [2] = '{10, 0};
  localparam int M_IV   [2] = '{4, 0};
  localparam int M_FALL [2] = '{0, 1};

  logic clk = 1'b0;
  logic rst;
  logic [CH-1:0] da, ea, db, eb, pa, ha, pb, hb;
  logic anya, anyb;

  always #5 clk = ~clk;

  key_repeat_pulse #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(3), .DELAY_CYCLES(10), .REPEAT_CYCLES(4), .ON_FALL(0)
  ) dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Data(da), .i_Enable(ea),
    .o_Pulse(pa), .o_Held(ha), .o_Any(anya)
  );

  key_repeat_pulse #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(3), .DELAY_CYCLES(0), .REPEAT_CYCLES(0), .ON_FALL(1)
  ) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Data(db), .i_Enable(eb),
    .o_Pulse(pb), .o_Held(hb), .o_Any(anyb)
  );

  int total = 0;
  int bad = 0;
  int nc = 0;
  int gt = 0;
  int first_held0 = -1;
  int qa0[$], qa2[$], qa3[$], qany[$], qb1[$];

  logic          m_deb   [2][CH];
  int            m_since [2][CH];
  logic [7:0]    m_hist  [2][CH];
  bit            m_armed [2][CH];
  int            m_tp    [2][CH];
  logic [CH-1:0] m_pulse [2];
  logic [CH-1:0] m_held  [2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Debounced level flips once DEB samples, all taken since the last flip, disagree with it.
  // Repeats fall at press+DLY+k*IV while the key stays active and enabled.
  task automatic model_step(input int c, input logic [CH-1:0] d, input logic [CH-1:0] e,
                            input logic r);
    logic f;
    f = (M_FALL[c] != 0);
    for (int i = 0; i < CH; i++) begin
      logic old_act, new_act, flip;
      int el;
      if (r) begin
        m_deb[c][i]   = d[i];
        m_since[c][i] = 0;
        m_hist[c][i]  = '0;
        m_armed[c][i] = 1'b0;
        m_pulse[c][i] = 1'b0;
      end else begin
        m_since[c][i]++;
        m_hist[c][i] = {m_hist[c][i][6:0], d[i]};
        old_act = m_deb[c][i] ^ f;
        flip = (m_since[c][i] >= M_DEB[c]);
        for (int k = 0; k < M_DEB[c]; k++)
          if (m_hist[c][i][k] == m_deb[c][i]) flip = 1'b0;
        if (flip) begin
          m_deb[c][i]   = ~m_deb[c][i];
          m_since[c][i] = 0;
        end
        new_act = m_deb[c][i] ^ f;
        m_pulse[c][i] = 1'b0;
        if (!e[i]) begin
          m_armed[c][i] = 1'b0;
        end else if (new_act && !old_act) begin
          m_pulse[c][i] = 1'b1;
          m_armed[c][i] = 1'b1;
          m_tp[c][i]    = gt;
        end else if (!new_act) begin
          m_armed[c][i] = 1'b0;
        end else if (m_armed[c][i] && M_DLY[c] > 0) begin
          el = gt - m_tp[c][i];
          if (el >= M_DLY[c] && ((el - M_DLY[c]) % M_IV[c]) == 0) m_pulse[c][i] = 1'b1;
        end
      end
      m_held[c][i] = m_deb[c][i] ^ f;
    end
  endtask

  always @(negedge clk) begin
    logic r;
    r = rst;
    model_step(0, da, ea, r);
    model_step(1, db, eb, r);
    gt++;
    if (r) nc = -1;
    else   nc++;
    #1;
    check("a_pulse", 32'(pa), 32'(m_pulse[0]));
    check("a_held",  32'(ha), 32'(m_held[0]));
    check("a_any",   32'(anya), 32'(|m_pulse[0]));
    check("b_pulse", 32'(pb), 32'(m_pulse[1]));
    check("b_held",  32'(hb), 32'(m_held[1]));
    check("b_any",   32'(anyb), 32'(|m_pulse[1]));
    if (!r) begin
      if (pa[0]) qa0.push_back(nc);
      if (pa[2]) qa2.push_back(nc);
      if (pa[3]) qa3.push_back(nc);
      if (anya)  qany.push_back(nc);
      if (pb[1]) qb1.push_back(nc);
      if (ha[0] === 1'b1 && first_held0 < 0) first_held0 = nc;
    end
  end

  initial begin
    int press_n, p, f;
    int exp0 [6] = '{2, 12, 16, 20, 24, 28};
    rst = 1'b1; da = '0; da[2] = 1'b1; ea = '1; db = '1; eb = '1;
    repeat (3) @(posedge clk);
    check("rst_pulse_a", 32'(pa), 32'h0);
    check("rst_held_a",  32'(ha), 32'h4);
    check("rst_held_b",  32'(hb), 32'h0);

    // Press ch0 held 30 cycles, ch1 glitch of 2 cycles, ch2 held through reset.
    rst = 1'b0; da[0] = 1'b1; da[1] = 1'b1;
    repeat (2) @(posedge clk);
    da[1] = 1'b0;
    repeat (28) @(posedge clk);
    da[0] = 1'b0;
    repeat (10) @(posedge clk);
    check("held0_first", 32'(first_held0), 32'd2);
    check("ch0_count", 32'(qa0.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check("ch0_time", 32'((qa0.size() > i) ? qa0[i] : -1), 32'(exp0[i]));
    check("ch2_held_reset", 32'(ha[2]), 32'd1);
    check("ch2_no_pulse", 32'(qa2.size()), 32'd0);
    check("ch1_held", 32'(ha[1]), 32'd0);

    // Release ch2 then press again.
    da[2] = 1'b0;
    repeat (6) @(posedge clk);
    da[2] = 1'b1; press_n = nc + 1;
    repeat (6) @(posedge clk);
    check("ch2_repress_cnt", 32'(qa2.size()), 32'd1);
    check("ch2_repress_t", 32'((qa2.size() > 0) ? qa2[0] : -1), 32'(press_n + 2));
    da[2] = 1'b0;
    repeat (8) @(posedge clk);

    // Simultaneous press on ch0 and ch3.
    qa0.delete(); qa3.delete(); qany.delete();
    da[0] = 1'b1; da[3] = 1'b1; p = nc + 1;
    repeat (5) @(posedge clk);
    check("sim_ch0", 32'((qa0.size() > 0) ? qa0[0] : -1), 32'(p + 2));
    check("sim_ch3", 32'((qa3.size() > 0) ? qa3[0] : -1), 32'(p + 2));
    check("sim_any", 32'((qany.size() > 0) ? qany[0] : -1), 32'(p + 2));

    // Disable ch0 while repeating, then re-enable while still held.
    repeat (10) @(posedge clk);
    ea[0] = 1'b0;
    repeat (5) @(posedge clk);
    ea[0] = 1'b1;
    repeat (15) @(posedge clk);
    check("dis_count", 32'(qa0.size()), 32'd2);
    check("dis_t1", 32'((qa0.size() > 1) ? qa0[1] : -1), 32'(p + 12));
    da[0] = 1'b0; da[3] = 1'b0;
    repeat (6) @(posedge clk);
    qa0.delete();
    da[0] = 1'b1; p = nc + 1;
    repeat (5) @(posedge clk);
    check("repress_ch0", 32'((qa0.size() > 0) ? qa0[0] : -1), 32'(p + 2));
    da[0] = 1'b0;
    repeat (6) @(posedge clk);

    // Active-low channel with repeat disabled.
    qb1.delete();
    db[1] = 1'b0; f = nc + 1;
    repeat (20) @(posedge clk);
    db[1] = 1'b1;
    repeat (8) @(posedge clk);
    check("fall_count", 32'(qb1.size()), 32'd1);
    check("fall_time", 32'((qb1.size() > 0) ? qb1[0] : -1), 32'(f + 2));

    // Random phase: per-channel toggle rates from glitchy to long holds.
    repeat (4000) begin
      @(posedge clk);
      for (int i = 0; i < CH; i++) begin
        int unsigned rng;
        rng = (i == 0) ? 3 : (i == 1) ? 15 : (i == 2) ? 40 : 90;
        if ($urandom_range(rng, 0) == 0) da[i] = ~da[i];
        if ($urandom_range(rng, 0) == 0) db[i] = ~db[i];
        if (ea[i] ? ($urandom_range(99, 0) == 0) : ($urandom_range(7, 0) == 0)) ea[i] = ~ea[i];
        if (eb[i] ? ($urandom_range(99, 0) == 0) : ($urandom_range(7, 0) == 0)) eb[i] = ~eb[i];
      end
      rst = ($urandom_range(699, 0) == 0);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_repeat_pulse.md
Name: key_repeat_pulse

Overview:
Multi-channel edge-to-pulse generator for the TM1638 key-scan path. Each channel debounces a raw key level and emits a one-cycle pulse on the debounced active edge. Optionally it auto-repeats pulses while the key stays held: a first delay, then a fixed interval. It sits between the TM1638 key-read decoder and the application command logic.

Parameters:
CHANNELS, 8, number of independent key channels (>=1)
DEBOUNCE_CYCLES, 4, consecutive differing samples required to accept a level change (>=1)
DELAY_CYCLES, 0, cycles from the press pulse to the first repeat pulse; 0 disables auto-repeat
REPEAT_CYCLES, 0, cycles between subsequent repeat pulses; 0 means use DELAY_CYCLES
ON_FALL, 0, 0 = active level high (press = rising edge); 1 = active level low (press = falling edge)

Ports:
i_Clk  input  1  clock; all state updates on the falling edge
i_Rst  input  1  reset, synchronous, active-high
i_Data  input  CHANNELS  raw key levels, one bit per channel
i_Enable  input  CHANNELS  per-channel pulse enable
o_Pulse  output  CHANNELS  registered one-cycle pulses (press and repeat)
o_Held  output  CHANNELS  registered debounced "active" level per channel
o_Any  output  1  combinational OR of o_Pulse

Behaviour:
- Reset (i_Rst high at a negedge):
  - Debounced level is loaded from i_Data, so a key held through reset gives no pulse.
  - Debounce and hold counters clear to 0. FSM goes to IDLE.
  - o_Pulse = 0. o_Held = the loaded level mapped by ON_FALL.
- Debounce, per channel:
  - Counter increments each cycle the raw level differs from the debounced level.
  - Counter clears whenever the two are equal.
  - On the DEBOUNCE_CYCLES-th consecutive differing sample, the debounced level updates and the counter clears.
  - If raw changes before negedge k and stays stable, the debounced level and o_Held change at negedge k+DEBOUNCE_CYCLES-1.
  - A glitch shorter than DEBOUNCE_CYCLES has no effect.
- FSM per channel: IDLE, DELAY, REPEAT.
  - IDLE -> DELAY on the debounced inactive-to-active edge with enable high. o_Pulse asserts at that same negedge. Hold counter clears.
  - If DELAY_CYCLES = 0, the FSM goes to IDLE-HELD behaviour instead: it stays in IDLE and gives no further pulses until release.
  - DELAY: hold counter increments each cycle. When it reaches DELAY_CYCLES: pulse, counter clears, go to REPEAT.
  - REPEAT: when the counter reaches the interval (REPEAT_CYCLES, or DELAY_CYCLES if that is 0): pulse, counter clears.
  - Debounced release in any state -> IDLE, counter clears, no pulse. ON_FALL does not add release pulses.
- Enable:
  - i_Enable low forces IDLE and suppresses o_Pulse. Debounce tracking continues.
  - Re-enabling while the key is held gives no pulse; a new press is required.
- Key held at reset: FSM stays in IDLE and gives no repeats until the key is released and pressed again.
- Pulse width: o_Pulse is high for exactly one cycle. Consecutive pulses on one channel are at least min(DELAY, interval) cycles apart. REPEAT pulses never coincide with the press pulse.
- Channel independence: channels never interact; simultaneous presses pulse in the same cycle.
- Counter widths: $clog2(max+1) of the respective limit, minimum 1 bit. Counters saturate-free by construction, since they clear on reaching the limit.
- Reset mid-operation: takes effect at the next negedge regardless of state. Any pending pulse is dropped.

Decomposition:
- Package key_repeat_pulse_pkg holds:
  - the FSM state enum (IDLE, DELAY, REPEAT);
  - a width helper function, cnt_w(limit);
  - the derived constant for the effective repeat interval.
- Sub-module key_repeat_channel implements one channel (debouncer, FSM, counters).
- The top instantiates CHANNELS copies via generate and forms o_Any.

Test Plan (CHANNELS=4, DEBOUNCE_CYCLES=3, DELAY_CYCLES=10, REPEAT_CYCLES=4, ON_FALL=0 unless noted):
- i_Data[0] rises before negedge 0 and is held 30 cycles, enable high -> o_Held[0]=1 from negedge 2; o_Pulse[0] high only after negedges 2, 12, 16, 20, 24, 28.
- i_Data[1] high for 2 cycles then low -> o_Pulse[1]=0 and o_Held[1]=0 throughout.
- i_Data[2]=1 during reset, held 40 cycles after reset -> o_Held[2]=1, no pulses; release then press again -> pulse after 3 debounce cycles.
- i_Data[0] and i_Data[3] rise in the same cycle -> o_Pulse[0], o_Pulse[3] and o_Any all high for the same single cycle.
- Channel 0 held and in REPEAT, i_Enable[0] dropped for 5 cycles then raised -> no pulses while disabled or after re-enable until release and re-press.
- ON_FALL=1, DELAY_CYCLES=0: i_Data[1] falls and stays low 20 cycles -> exactly one pulse 2 negedges after the fall; rising back gives no pulse.
